// File: rtl/clint_hart_timer.sv
// -----------------------------------------------------------------------------
// clint_hart_timer
//
// Core-local interruptor for NUM_HARTS harts. It holds a 64-bit free-running
// mtime, one 64-bit mtimecmp and one msip bit per hart, all reachable over a
// 32-bit request/response bus. Every request is accepted in the cycle it is
// presented and answered exactly one cycle later.
//
// Address map (byte offsets from BASE_ADDR):
//   0x0000 + 4h          msip[h]          (bit 0 only)
//   0x4000 + 8h / +4     mtimecmp[h] lo/hi
//   0xBFF8 / 0xBFFC      mtime lo/hi
// Any other offset, a hart index >= NUM_HARTS, or addr[1:0] != 0 is an error:
// writes are dropped, reads return 0, and clint_err_o is raised with the
// response.
//
// Optional feature macro: CLINT_PRESCALER_EN
//   defined   : mtime advances once every TICK_DIV clocks; a bus write to
//               either mtime half restarts the prescaler count.
//   undefined : mtime advances every clock and TICK_DIV has no effect.
//
// Ports:
//   clk                  clock, all state on the rising edge
//   rst                  asynchronous reset, active low
//   clint_valid_i        bus request this cycle
//   clint_write_valid_i  1 = write, 0 = read (qualified by clint_valid_i)
//   clint_addr_i         byte address
//   clint_wdata_i        write data
//   clint_rdata_o        read data, valid with clint_rvalid_o
//   clint_rvalid_o       one response strobe per accepted request
//   clint_err_o          with clint_rvalid_o: unmapped/misaligned address
//   mtip_o               per-hart timer interrupt pending (mtime >= mtimecmp)
//   msip_o               per-hart software interrupt pending
// -----------------------------------------------------------------------------
module clint_hart_timer #(
  parameter int          NUM_HARTS = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clint_valid_i,
  input  logic                 clint_write_valid_i,
  input  logic [31:0]          clint_addr_i,
  input  logic [31:0]          clint_wdata_i,
  output logic [31:0]          clint_rdata_o,
  output logic                 clint_rvalid_o,
  output logic                 clint_err_o,
  output logic [NUM_HARTS-1:0] mtip_o,
  output logic [NUM_HARTS-1:0] msip_o
);

  // Architectural state
  logic [63:0]          mtime;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;
  logic                 tick;

  // Address decode and read mux (request cycle)
  logic [29:0]          word_off;
  logic                 aligned;
  logic                 in_msip_region;
  logic                 in_cmp_region;
  logic                 sel_time_lo;
  logic                 sel_time_hi;
  logic [NUM_HARTS-1:0] sel_msip;
  logic [NUM_HARTS-1:0] sel_cmp_lo;
  logic [NUM_HARTS-1:0] sel_cmp_hi;
  logic                 hit;
  logic                 wr_en;
  logic                 wr_time_lo;
  logic                 wr_time_hi;
  logic [31:0]          rd_val;

  // The base is word aligned, so decoding works on word offsets; the low two
  // address bits only matter for the alignment check.
  assign word_off = clint_addr_i[31:2] - BASE_ADDR[31:2];
  assign aligned  = (clint_addr_i[1:0] == 2'b00);

  always_comb begin
    in_msip_region = aligned && (word_off[29:12] == 18'h0);
    in_cmp_region  = aligned && (word_off[29:12] == 18'h1);
    sel_time_lo    = aligned && (word_off == 30'h2FFE);
    sel_time_hi    = aligned && (word_off == 30'h2FFF);
    sel_msip       = '0;
    sel_cmp_lo     = '0;
    sel_cmp_hi     = '0;
    // Per-hart equality decode: indices beyond NUM_HARTS simply match nothing.
    for (int h = 0; h < NUM_HARTS; h++) begin
      sel_msip[h]   = in_msip_region && (word_off[11:0] == 12'(h));
      sel_cmp_lo[h] = in_cmp_region && (word_off[11:1] == 11'(h)) && !word_off[0];
      sel_cmp_hi[h] = in_cmp_region && (word_off[11:1] == 11'(h)) &&  word_off[0];
    end
    hit = sel_time_lo || sel_time_hi || (|sel_msip) || (|sel_cmp_lo) || (|sel_cmp_hi);
  end

  always_comb begin
    rd_val = '0;
    if (sel_time_lo) rd_val = mtime[31:0];
    if (sel_time_hi) rd_val = mtime[63:32];
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (sel_msip[h])   rd_val = {31'b0, msip[h]};
      if (sel_cmp_lo[h]) rd_val = mtimecmp[h][31:0];
      if (sel_cmp_hi[h]) rd_val = mtimecmp[h][63:32];
    end
  end

  assign wr_en      = clint_valid_i && clint_write_valid_i;
  assign wr_time_lo = wr_en && sel_time_lo;
  assign wr_time_hi = wr_en && sel_time_hi;

  // Tick generation
`ifdef CLINT_PRESCALER_EN
  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] presc_cnt;

  // The tick fires on the cycle the count wraps; an mtime write restarts it.
  assign tick = (presc_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_cnt <= '0;
    end else if (wr_time_lo || wr_time_hi || tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_tick_div;
  assign unused_tick_div = (TICK_DIV != 0);
  assign tick            = 1'b1;
`endif

  // mtime: a bus write to one half wins over the tick and leaves the other
  // half untouched; the 64-bit add carries across halves and wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime <= '0;
    end else if (wr_time_lo) begin
      mtime[31:0] <= clint_wdata_i;
    end else if (wr_time_hi) begin
      mtime[63:32] <= clint_wdata_i;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp[h] <= '1;
      end
      msip <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr_en && sel_cmp_lo[h]) mtimecmp[h][31:0]  <= clint_wdata_i;
        if (wr_en && sel_cmp_hi[h]) mtimecmp[h][63:32] <= clint_wdata_i;
        if (wr_en && sel_msip[h])   msip[h]            <= clint_wdata_i[0];
      end
    end
  end

  // Stage p1: registered compare and bus response
  logic [NUM_HARTS-1:0] mtip_p1;
  logic                 vld_p1;
  logic                 err_p1;
  logic [31:0]          rdata_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtip_p1 <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtip_p1[h] <= (mtime >= mtimecmp[h]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= clint_valid_i;
      err_p1   <= clint_valid_i && !hit;
      rdata_p1 <= (clint_valid_i && !clint_write_valid_i && hit) ? rd_val : 32'h0;
    end
  end

  assign clint_rvalid_o = vld_p1;
  assign clint_err_o    = err_p1;
  assign clint_rdata_o  = rdata_p1;
  assign mtip_o         = mtip_p1;
  assign msip_o         = msip;

endmodule
